request_unit: RTL and testbench

- Memory request sequencer between the single-cycle datapath and the cache-side datapath_cache_if signals.
- Issues instruction-fetch and data-access requests and serialises a load/store's data access after its fetch.
- Produces the PC-advance enable and the register-file write permission, so the PC and register file update only on a completed instruction.
- Provides sticky halt and a stall-cycle performance counter.

---
 rtl/request_unit.sv | 123 ++++++++++++
 tb/tb_request_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// request_unit: sequences instruction-fetch and data-access requests for the
// single-cycle datapath, gates PC advance and register-file writes to completed
// instructions, and keeps a sticky halt flag plus a saturating stall counter.
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             halt_req,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             rf_wen_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              dmemren_reg, dmemren_next;
    logic              dmemwen_reg, dmemwen_next;
    logic              halt_reg, halt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic              pc_en_c;
    logic              rf_wen_en_c;
    logic              imemren_c;

    // State and latched data-request registers; all clear asynchronously on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= FETCH;
            dmemren_reg   <= 1'b0;
            dmemwen_reg   <= 1'b0;
            halt_reg      <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            dmemren_reg   <= dmemren_next;
            dmemwen_reg   <= dmemwen_next;
            halt_reg      <= halt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Next-state, request latching and completion strobes.
    always_comb begin
        state_next   = state_reg;
        dmemren_next = dmemren_reg;
        dmemwen_next = dmemwen_reg;
        halt_next    = halt_reg;
        pc_en_c      = 1'b0;
        rf_wen_en_c  = 1'b0;
        imemren_c    = 1'b0;
        case (state_reg)
            FETCH: begin
                imemren_c    = 1'b1;
                dmemren_next = 1'b0;
                dmemwen_next = 1'b0;
                if (ihit) begin
                    if (halt_req) begin
                        // HALT takes priority over any decoded memory access.
                        state_next = HALTED;
                        halt_next  = 1'b1;
                    end else if (memread || memwrite) begin
                        // Store wins when both are decoded.
                        state_next   = DATA;
                        dmemwen_next = memwrite;
                        dmemren_next = memread & ~memwrite;
                    end else begin
                        pc_en_c     = 1'b1;
                        rf_wen_en_c = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_en_c      = 1'b1;
                    rf_wen_en_c  = 1'b1;
                    state_next   = FETCH;
                    dmemren_next = 1'b0;
                    dmemwen_next = 1'b0;
                end
            end
            HALTED: begin
                dmemren_next = 1'b0;
                dmemwen_next = 1'b0;
                halt_next    = 1'b1;
            end
            default: begin
                state_next   = FETCH;
                dmemren_next = 1'b0;
                dmemwen_next = 1'b0;
            end
        endcase
    end

    // Stall counter: counts live cycles without PC advance, saturating at all-ones.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((state_reg != HALTED) && !pc_en_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    assign imemREN   = imemren_c;
    assign dmemREN   = dmemren_reg;
    assign dmemWEN   = dmemwen_reg;
    assign pc_en     = pc_en_c;
    assign rf_wen_en = rf_wen_en_c;
    assign halt      = halt_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: expected output vectors are queued as each
// step is driven and popped when the outputs are sampled mid-cycle.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, memread, memwrite, halt_req;
    logic        imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt;
    logic [31:0] stall_cnt;
    logic        imemREN4, dmemREN4, dmemWEN4, pc_en4, rf_wen_en4, halt4;
    logic [3:0]  stall_cnt4;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    logic [5:0] sb_q[$];

    always #5 CLK = ~CLK;

    request_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memread(memread),
        .memwrite(memwrite), .halt_req(halt_req), .imemREN(imemREN),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc_en(pc_en),
        .rf_wen_en(rf_wen_en), .halt(halt), .stall_cnt(stall_cnt)
    );

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memread(memread),
        .memwrite(memwrite), .halt_req(halt_req), .imemREN(imemREN4),
        .dmemREN(dmemREN4), .dmemWEN(dmemWEN4), .pc_en(pc_en4),
        .rf_wen_en(rf_wen_en4), .halt(halt4), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input int c);
        return (c > 15) ? 32'd15 : c;
    endfunction

    // Compare the output vector and both counters against the scoreboard/model.
    task automatic sample(input string tag);
        logic [5:0] exp_v;
        exp_v = sb_q.pop_front();
        check({tag, ".vec"}, {26'd0, imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt}, {26'd0, exp_v});
        check({tag, ".cnt"}, stall_cnt, exp_cnt);
        check({tag, ".cnt4"}, {28'd0, stall_cnt4}, sat4(exp_cnt));
        $display("[TB] %-10s ihit=%0b dhit=%0b mr=%0b mw=%0b hr=%0b vec=%b cnt=%0d cnt4=%0d",
                 tag, ihit, dhit, memread, memwrite, halt_req,
                 {imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt}, stall_cnt, stall_cnt4);
    endtask

    // One clock of stimulus, entered just after a falling edge.
    // vec = {imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt}
    task automatic step(input string tag, input logic ih, input logic dh, input logic mr,
                        input logic mw, input logic hr, input logic [5:0] vec, input logic halted);
        ihit = ih; dhit = dh; memread = mr; memwrite = mw; halt_req = hr;
        sb_q.push_back(vec);
        #1;
        sample(tag);
        @(negedge CLK);
        if (!halted && !vec[2]) exp_cnt++;
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 0; dhit = 0; memread = 0; memwrite = 0; halt_req = 0;
        #2;
        sb_q.push_back(6'b100000);
        sample("reset");
        @(negedge CLK);
        nRST = 1'b1;
        exp_cnt = 0;

        // Idle fetch, waiting on ihit
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 6'b100000, 0);
        // ALU op completes in its ihit cycle
        step("alu", 1, 0, 0, 0, 0, 6'b100110, 0);
        // Load with two wait cycles
        step("ld_issue", 1, 0, 1, 0, 0, 6'b100000, 0);
        step("ld_wait", 0, 0, 0, 0, 0, 6'b010000, 0);
        step("ld_wait", 0, 0, 0, 0, 0, 6'b010000, 0);
        step("ld_done", 0, 1, 0, 0, 0, 6'b010110, 0);
        step("post_ld", 0, 0, 0, 0, 0, 6'b100000, 0);
        // Store with both decodes set, spurious ihit and changing decodes during DATA
        step("st_issue", 1, 0, 1, 1, 0, 6'b100000, 0);
        step("st_wait", 1, 0, 1, 0, 0, 6'b001000, 0);
        step("st_done", 1, 1, 0, 0, 0, 6'b001110, 0);
        step("post_st", 0, 0, 0, 0, 0, 6'b100000, 0);
        step("alu2", 1, 1, 0, 0, 0, 6'b100110, 0);
        // HALT overrides the store decode; sticky and frozen counter
        step("halt_req", 1, 0, 0, 1, 1, 6'b100000, 0);
        for (int i = 0; i < 10; i++) step("halted", 1, i[0], 1, 1, 1, 6'b000001, 1);

        // Reset out of HALTED, then async reset in the middle of a load
        nRST = 1'b0;
        #1;
        exp_cnt = 0;
        sb_q.push_back(6'b100000);
        sample("rst_halt");
        @(negedge CLK);
        nRST = 1'b1;
        step("ld2_issue", 1, 0, 1, 0, 0, 6'b100000, 0);
        ihit = 0; dhit = 0; memread = 0; memwrite = 0; halt_req = 0;
        #1;
        sb_q.push_back(6'b010000);
        sample("ld2_wait");
        #1;
        nRST = 1'b0;
        #1;
        exp_cnt = 0;
        sb_q.push_back(6'b100000);
        sample("rst_mid");
        @(negedge CLK);
        nRST = 1'b1;

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, 0, 0, 6'b100000, 0);
        check("sat_final4", {28'd0, stall_cnt4}, 32'd15);
        check("sat_final32", stall_cnt, 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
